flag_stack_reg: RTL and testbench

FLAG_STACK_REG -- requirements
Module: flag_stack_reg

---
 rtl/flag_stack_reg.sv | 109 ++++++++++
 tb/tb_flag_stack_reg.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/flag_stack_reg.sv
// Processor status-flag register (CY, Z, S, V, P) with a small LIFO save/restore
// stack and a sticky error for illegal stack operations.
module flag_stack_reg #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic [WIDTH-1:0]             ALU_RESULT,
    input  logic                         ALU_CY,
    input  logic                         ALU_V,
    input  logic                         FLAG_WE,
    input  logic [4:0]                   FLAG_MASK,
    input  logic                         PUSH,
    input  logic                         POP,
    input  logic                         LOAD,
    input  logic [4:0]                   FLAGS_IN,
    input  logic                         ERR_CLR,
    output logic                         CY,
    output logic                         Z,
    output logic                         S,
    output logic                         V,
    output logic                         P,
    output logic [$clog2(DEPTH+1)-1:0]   STK_CNT,
    output logic                         STK_FULL,
    output logic                         STK_EMPTY,
    output logic                         STK_ERR
);
    localparam int CW = $clog2(DEPTH+1);

    // Flag vector ordering is {P,V,S,Z,CY}
    logic [4:0]       flags_q, flags_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             err_q, err_d;
    logic [4:0]       stack_q [DEPTH];

    logic             full, empty;
    logic             both, push_ok, pop_ok, err_ev;
    logic [4:0]       derived, masked, top;
    logic [DEPTH-1:0] wr_sel, rd_sel;

    assign full    = (cnt_q == CW'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign both    = PUSH & POP;
    assign push_ok = PUSH & ~POP & ~full;
    assign pop_ok  = POP & ~PUSH & ~empty;
    assign err_ev  = both | (PUSH & full) | (POP & empty);

    assign derived = {~^ALU_RESULT, ALU_V, ALU_RESULT[WIDTH-1], ~|ALU_RESULT, ALU_CY};
    assign masked  = (flags_q & ~FLAG_MASK) | (derived & FLAG_MASK);

    // Entry gi is written when it is the next free slot, read when it is the top.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_sel
            assign wr_sel[gi] = push_ok && (cnt_q == CW'(gi));
            assign rd_sel[gi] = (cnt_q == CW'(gi + 1));
        end
    endgenerate

    always_comb begin
        top = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (rd_sel[i]) top = stack_q[i];
        end
    end

    always_comb begin
        flags_d = flags_q;
        cnt_d   = cnt_q;
        if (push_ok) cnt_d = cnt_q + CW'(1);
        // Any POP (legal or not) blocks LOAD and FLAG_WE for this cycle.
        if (pop_ok) begin
            cnt_d   = cnt_q - CW'(1);
            flags_d = top;
        end else if (!POP) begin
            if (LOAD)         flags_d = FLAGS_IN;
            else if (FLAG_WE) flags_d = masked;
        end
        err_d = err_ev ? 1'b1 : (ERR_CLR ? 1'b0 : err_q);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            flags_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            flags_q <= flags_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge CLK) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (wr_sel[i]) stack_q[i] <= flags_q;
        end
    end

    assign CY        = flags_q[0];
    assign Z         = flags_q[1];
    assign S         = flags_q[2];
    assign V         = flags_q[3];
    assign P         = flags_q[4];
    assign STK_CNT   = cnt_q;
    assign STK_FULL  = full;
    assign STK_EMPTY = empty;
    assign STK_ERR   = err_q;
endmodule

// File: tb/tb_flag_stack_reg.sv
// Scoreboarded bench for flag_stack_reg: directed scenarios then random traffic,
// checked against a queue-based reference model.
module tb_flag_stack_reg;
    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH+1);
    localparam int VW    = 5 + CW + 3;

    logic             CLK = 1'b0;
    logic             RST;
    logic [WIDTH-1:0] ALU_RESULT;
    logic             ALU_CY, ALU_V, FLAG_WE, PUSH, POP, LOAD, ERR_CLR;
    logic [4:0]       FLAG_MASK, FLAGS_IN;
    logic             CY, Z, S, V, P, STK_FULL, STK_EMPTY, STK_ERR;
    logic [CW-1:0]    STK_CNT;

    flag_stack_reg #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .CLK(CLK), .RST(RST), .ALU_RESULT(ALU_RESULT), .ALU_CY(ALU_CY), .ALU_V(ALU_V),
        .FLAG_WE(FLAG_WE), .FLAG_MASK(FLAG_MASK), .PUSH(PUSH), .POP(POP), .LOAD(LOAD),
        .FLAGS_IN(FLAGS_IN), .ERR_CLR(ERR_CLR), .CY(CY), .Z(Z), .S(S), .V(V), .P(P),
        .STK_CNT(STK_CNT), .STK_FULL(STK_FULL), .STK_EMPTY(STK_EMPTY), .STK_ERR(STK_ERR)
    );

    always #5 CLK = ~CLK;

    // Reference model: flags {P,V,S,Z,CY}, stack as a queue, sticky error
    logic [4:0]  m_flags;
    logic [4:0]  m_stk[$];
    logic        m_err;
    logic [VW-1:0] exp_q[$];
    string       name_q[$];

    int checks = 0;
    int errors = 0;
    int txn    = 0;

    function automatic logic [VW-1:0] actual();
        return {P, V, S, Z, CY, STK_CNT, STK_FULL, STK_EMPTY, STK_ERR};
    endfunction

    function automatic logic [VW-1:0] model_vec();
        int n = m_stk.size();
        return {m_flags, CW'(n), (n == DEPTH), (n == 0), m_err};
    endfunction

    task automatic check_now(input string nm, input logic [VW-1:0] e);
        logic [VW-1:0] a = actual();
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, a, e);
        end else
            $display("chk %s value=%h ok", nm, a);
    endtask

    task automatic model_reset();
        m_flags = '0;
        m_stk.delete();
        m_err = 1'b0;
    endtask

    task automatic idle();
        ALU_RESULT = '0; ALU_CY = 0; ALU_V = 0; FLAG_WE = 0; FLAG_MASK = '0;
        PUSH = 0; POP = 0; LOAD = 0; FLAGS_IN = '0; ERR_CLR = 0;
    endtask

    task automatic op(input string nm, input logic push, input logic pop, input logic load,
                      input logic [4:0] fin, input logic we, input logic [4:0] mask,
                      input logic [WIDTH-1:0] res, input logic cy, input logic v,
                      input logic clr);
        logic       ev;
        logic [4:0] d;
        @(negedge CLK);
        PUSH = push; POP = pop; LOAD = load; FLAGS_IN = fin; FLAG_WE = we;
        FLAG_MASK = mask; ALU_RESULT = res; ALU_CY = cy; ALU_V = v; ERR_CLR = clr;
        ev = 1'b0;
        if (push && pop) ev = 1'b1;
        else if (pop) begin
            if (m_stk.size() == 0) ev = 1'b1;
            else m_flags = m_stk.pop_back();
        end else begin
            if (push) begin
                if (m_stk.size() == DEPTH) ev = 1'b1;
                else m_stk.push_back(m_flags);
            end
            if (load) m_flags = fin;
            else if (we) begin
                d[0] = cy;
                d[1] = (res == 0);
                d[2] = res[WIDTH-1];
                d[3] = v;
                d[4] = ($countones(res) % 2 == 0);
                for (int b = 0; b < 5; b++) if (mask[b]) m_flags[b] = d[b];
            end
        end
        if (ev) m_err = 1'b1;
        else if (clr) m_err = 1'b0;
        exp_q.push_back(model_vec());
        name_q.push_back(nm);
    endtask

    // Monitor: every cycle the DUT presents a new state; compare it to the next expectation.
    initial begin
        logic [VW-1:0] e, a;
        string nm;
        forever begin
            @(posedge CLK);
            #1;
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                a  = actual();
                checks++;
                txn++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL txn %0d %s actual=%h required=%h", txn, nm, a, e);
                end else
                    $display("txn %0d %s state=%h ok", txn, nm, a);
            end
        end
    end

    initial begin
        idle();
        RST = 1'b1;
        model_reset();
        #1;
        check_now("reset_state", model_vec());
        @(negedge CLK);
        RST = 1'b0;

        // Flag derivation
        op("deriv_zero", 0, 0, 0, 5'h00, 1, 5'h1F, 8'h00, 1, 0, 0);
        op("deriv_81",   0, 0, 0, 5'h00, 1, 5'h1F, 8'h81, 0, 0, 0);
        // Mask
        op("load_zero",  0, 0, 1, 5'h00, 0, 5'h00, 8'h00, 0, 0, 0);
        op("mask_z",     0, 0, 0, 5'h00, 1, 5'b00010, 8'h00, 1, 0, 0);
        op("we_off",     0, 0, 0, 5'h00, 0, 5'h1F, 8'h55, 1, 1, 0);
        // Push four distinct vectors, overflow, LIFO pops
        op("load_03",    0, 0, 1, 5'h03, 0, 5'h00, 8'h00, 0, 0, 0);
        op("push_ld0c",  1, 0, 1, 5'h0C, 0, 5'h00, 8'h00, 0, 0, 0);
        op("push_ld15",  1, 0, 1, 5'h15, 0, 5'h00, 8'h00, 0, 0, 0);
        op("push_ld1a",  1, 0, 1, 5'h1A, 0, 5'h00, 8'h00, 0, 0, 0);
        op("push_full",  1, 0, 0, 5'h00, 0, 5'h00, 8'h00, 0, 0, 0);
        op("push_ovf",   1, 0, 1, 5'h11, 0, 5'h00, 8'h00, 0, 0, 0);
        for (int i = 0; i < 4; i++)
            op("pop_lifo", 0, 1, 0, 5'h00, 0, 5'h00, 8'h00, 0, 0, 0);
        // Underflow with LOAD, then clear
        op("pop_unf",    0, 1, 1, 5'h1F, 1, 5'h1F, 8'h00, 1, 1, 0);
        op("err_clr",    0, 0, 0, 5'h00, 0, 5'h00, 8'h00, 0, 0, 1);
        op("clr_vs_err", 0, 1, 0, 5'h00, 0, 5'h00, 8'h00, 0, 0, 1);
        op("err_clr2",   0, 0, 0, 5'h00, 0, 5'h00, 8'h00, 0, 0, 1);
        // Simultaneous push with flag update, then push+pop
        op("load_01",    0, 0, 1, 5'h01, 0, 5'h00, 8'h00, 0, 0, 0);
        op("push_we",    1, 0, 0, 5'h00, 1, 5'b00010, 8'h00, 1, 0, 0);
        op("push_pop",   1, 1, 1, 5'h1F, 1, 5'h1F, 8'h00, 0, 0, 0);
        op("pop_top",    0, 1, 0, 5'h00, 0, 5'h00, 8'h00, 0, 0, 0);
        // Async reset mid-cycle with three entries stacked and all flags set
        op("load_1f",    0, 0, 1, 5'h1F, 0, 5'h00, 8'h00, 0, 0, 0);
        for (int i = 0; i < 3; i++)
            op("push_fill", 1, 0, 0, 5'h00, 0, 5'h00, 8'h00, 0, 0, 0);
        op("push_pop_e", 1, 1, 0, 5'h00, 0, 5'h00, 8'h00, 0, 0, 0);
        @(negedge CLK);
        idle();
        @(posedge CLK);
        #3;
        RST = 1'b1;
        model_reset();
        #1;
        check_now("async_reset", model_vec());
        @(negedge CLK);
        check_now("reset_hold", model_vec());
        RST = 1'b0;
        op("first_after_rst", 0, 0, 1, 5'h0A, 0, 5'h00, 8'h00, 0, 0, 0);

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            int r = $urandom_range(0, 9);
            logic pu = (r < 4);
            logic po = (r >= 4 && r < 7);
            if ($urandom_range(0, 19) == 0) begin pu = 1; po = 1; end
            op("rand", pu, po, ($urandom_range(0, 3) == 0), 5'($urandom),
               1'($urandom), 5'($urandom), WIDTH'($urandom), 1'($urandom), 1'($urandom),
               ($urandom_range(0, 7) == 0));
        end

        @(negedge CLK);
        idle();
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge CLK);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain actual=%0d pending required=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
